// File: rtl/flash_reader.sv
// flash_reader: SPI-flash (mode 0) burst reader. It sends READ (03h) or
// FAST_READ (0Bh + dummy byte) with an address, then streams back len bytes.
// It can optionally run one automatic boot read straight after reset release.
// Ports:
//   clock, reset (async, active low), ce (bit-engine tick, half SPI period)
//   start/addr/len : request; sampled only in IDLE
//   busy/done      : transaction in progress / one-clock completion pulse
//   q/qv           : received byte and its one-clock update strobe
//   cs/ck/mosi/miso: flash pins (cs active low, ck idles low)
module flash_reader #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned FAST      = 0,
  parameter int unsigned CSH_T     = 8,
  parameter int unsigned BOOT      = 1,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(24'h00704D),
  parameter logic [LEN_W-1:0]  BOOT_LEN  = LEN_W'(1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        q,
  output logic              qv,
  output logic              cs,
  output logic              ck,
  input  logic              miso,
  output logic              mosi
);

  localparam int unsigned TX_W  = 8 + ADDR_W + ((FAST != 0) ? 8 : 0);
  localparam int unsigned CSH_W = (CSH_T < 1) ? 1 : $clog2(CSH_T + 1);
  localparam logic [7:0]  CMD_BYTE = (FAST != 0) ? 8'h0B : 8'h03;
  localparam logic [5:0]  ADDR_LAST = 6'(ADDR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_CSH, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END
  } state_t;

  state_t            state;
  logic [CSH_W-1:0]  csh_cnt;
  logic [5:0]        bit_cnt;
  logic [TX_W-1:0]   tx;
  logic [6:0]        rx;
  logic [LEN_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic              boot_pend;

  logic [TX_W-1:0]   hdr;
  logic [LEN_W-1:0]  acc_len;
  logic [ADDR_W-1:0] acc_addr;

  // Outgoing header: command, address, and the dummy byte for FAST_READ.
  generate
    if (FAST != 0) begin : g_fast
      assign hdr = TX_W'({CMD_BYTE, addr_r, 8'h00});
    end else begin : g_read
      assign hdr = TX_W'({CMD_BYTE, addr_r});
    end
  endgenerate

  // A pending boot read takes precedence over the external request.
  assign acc_len  = boot_pend ? BOOT_LEN  : len;
  assign acc_addr = boot_pend ? BOOT_ADDR : addr;

  // Transaction sequencer and bit engine; ck level doubles as the tick phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      csh_cnt   <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      byte_cnt  <= '0;
      addr_r    <= '0;
      boot_pend <= (BOOT != 0);
      busy      <= 1'b0;
      done      <= 1'b0;
      q         <= 8'h00;
      qv        <= 1'b0;
      cs        <= 1'b1;
      ck        <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;
      qv   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || boot_pend) begin
            boot_pend <= 1'b0;
            addr_r    <= acc_addr;
            byte_cnt  <= acc_len;
            csh_cnt   <= '0;
            busy      <= 1'b1;
            state     <= (acc_len == '0) ? S_ZERO : S_CSH;
          end
        end
        // Zero-length request finishes without touching the bus.
        S_ZERO: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        // Hold cs high for the deselect gap, then drop it with the first bit.
        S_CSH: if (ce) begin
          if (csh_cnt == CSH_W'(CSH_T)) begin
            cs      <= 1'b0;
            mosi    <= hdr[TX_W-1];
            tx      <= hdr << 1;
            bit_cnt <= '0;
            state   <= S_CMD;
          end else begin
            csh_cnt <= csh_cnt + CSH_W'(1);
          end
        end
        S_CMD, S_ADDR, S_DUMMY: if (ce) begin
          if (!ck) begin
            ck <= 1'b1;
            rx <= {rx[5:0], miso};
          end else begin
            ck      <= 1'b0;
            mosi    <= tx[TX_W-1];
            tx      <= tx << 1;
            bit_cnt <= bit_cnt + 6'd1;
            if (state == S_CMD && bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              state   <= S_ADDR;
            end else if (state == S_ADDR && bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= (FAST != 0) ? S_DUMMY : S_DATA;
            end else if (state == S_DUMMY && bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end
          end
        end
        // Eighth rising edge of a byte completes it; exit after the last byte.
        S_DATA: if (ce) begin
          if (!ck) begin
            ck <= 1'b1;
            rx <= {rx[5:0], miso};
            if (bit_cnt == 6'd7) begin
              q        <= {rx, miso};
              qv       <= 1'b1;
              byte_cnt <= byte_cnt - LEN_W'(1);
            end
          end else begin
            ck      <= 1'b0;
            mosi    <= 1'b0;
            bit_cnt <= (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
            if (bit_cnt == 6'd7 && byte_cnt == '0) begin
              state <= S_END;
            end
          end
        end
        S_END: if (ce) begin
          cs    <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/flash_reader.md
Name: flash_reader

Overview:
- Parametrised SPI-flash burst reader; the next generation of the boot-time flash config probe.
- Issues a READ (03h) or FAST_READ (0Bh) at an arbitrary address and streams back 1..MAX_LEN bytes, one byte strobe per byte.
- Optional automatic boot read out of reset.
- Sits between the flash pins and boot/config logic: video-mode straps, ROM loader.
- Contains its own bit engine.

Parameters:
- ADDR_W, 24, flash address width in bits; must be a multiple of 8, range 16..32.
- LEN_W, 8, width of the length port; MAX_LEN = 2**LEN_W-1.
- FAST, 0, 1 selects FAST_READ (0Bh) with one 00h dummy byte after the address; 0 selects READ (03h).
- CSH_T, 8, minimum cs-high time in ce ticks before each transaction.
- BOOT, 1, 1 runs one automatic read after reset release.
- BOOT_ADDR, 24'h00704D, boot-read address.
- BOOT_LEN, 1, boot-read byte count.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- ce, in, 1, bit-engine clock enable; one ce tick = half an SPI clock period.
- start, in, 1, single-cycle request; sampled only in IDLE.
- addr, in, ADDR_W, start address; captured on an accepted start.
- len, in, LEN_W, byte count; captured on an accepted start.
- busy, out, 1, high from an accepted start (or boot) until done.
- done, out, 1, one-clock pulse at end of transaction.
- q, out, 8, received byte; held until the next byte.
- qv, out, 1, one-clock pulse when q is updated.
- cs, out, 1, flash chip select, active low.
- ck, out, 1, SPI clock, mode 0, idle low.
- miso, in, 1, flash data out.
- mosi, out, 1, flash data in.

Behaviour:
- Reset (async, reset=0):
  - Outputs: cs=1, ck=0, mosi=0, busy=0, done=0, qv=0, q=00h.
  - State IDLE; CSH counter cleared.
  - Asserting reset mid-transfer aborts immediately with no done pulse.
- Start acceptance:
  - In IDLE, start=1 latches addr and len and sets busy on the next clock. Acceptance does not depend on ce.
  - start while busy is ignored.
  - With BOOT=1, the first clock after reset release behaves as start with BOOT_ADDR/BOOT_LEN.
- State machine (after acceptance, all transitions advance only on ce ticks):
  - IDLE -> CSH -> CMD -> ADDR -> [DUMMY if FAST] -> DATA -> END -> IDLE.
  - CSH: cs=1 for CSH_T ce ticks, then cs goes low.
  - CMD: 8 bits.
  - ADDR: ADDR_W bits, MSB first.
  - DUMMY: 8 bits of 00h.
  - DATA: 8*len bits.
  - END: ck=0, then cs=1 on the next ce tick; in the same clock, done=1 for one clock and busy=0.
- len=0: no bus activity at all (cs stays high); done pulses one clock after acceptance; busy is high for exactly that one clock.
- Bit timing, two ce ticks per bit:
  - Tick A: ck 0->1; miso is sampled into the shift register on this tick.
  - Tick B: ck 1->0; mosi updates to the next output bit.
  - The first mosi bit (command MSB) is driven in the same ce tick that cs falls, so it is stable before the first rising ck.
  - mosi=0 during DATA.
- Byte delivery:
  - After the 8th tick A of each data byte, q gets the assembled byte (first received bit = MSB) and qv pulses one clock.
  - A byte counter decrements per byte; DATA exits when it reaches 0.
- ce held low: all state, including ck level, freezes; no timeout.
- ce=1 continuously is legal; the SPI clock is then clock/2.
- Address counter width is ADDR_W; the block does not wrap or check the address (the flash wraps internally).

Test Plan:
- Boot, FAST=0, BOOT_ADDR=00704Dh, BOOT_LEN=1, flash model returns 02h, ce every 4th clock:
  - mosi carries 03h,00h,70h,4Dh.
  - One qv pulse with q=02h, then done pulse.
  - cs high before the 8 ce-tick gap and after the transaction.
  - 40 rising ck edges total.
- start addr=012345h, len=4, model returns A5h,5Ah,FFh,00h:
  - Four qv pulses with those values in order.
  - busy high start-to-done.
  - done coincident with cs rising.
- FAST=1, addr=000010h, len=2:
  - Bus shows 0Bh, 00h, 00h, 10h, 00h (dummy), then 16 data clocks.
  - The first data byte is the model byte at 10h.
- start with len=0: cs never falls; done pulses one clock after acceptance; busy is high for exactly one clock.
- start pulsed again mid-DATA: ignored, no change to the byte stream. Then reset=0 asserted mid-ADDR: cs=1, ck=0, busy=0 asynchronously; no done pulse.
- ce held low for 50 clocks in the middle of a data bit: ck, cs and mosi stay frozen. Resuming ce completes the transfer with correct bytes.
